swizzle_packer: RTL and testbench
=================================

Name: swizzle_packer

Overview:
- Parametrised, sequential successor to the combinational concatenate/replicate swizzle.
- Accepts narrow IN_W-bit beats over a valid/ready stream and builds BEATS-wide output words. Two modes:
  - Concatenation: successive beats placed MSB-first.
  - Replication: one beat copied BEATS times.
- A partial word can be flushed early; its unused low slots are filled with a pad bit.
- Sits between narrow field producers and wide bus consumers.

Parameters:
- IN_W, 3, width of one input beat (>=1).
- BEATS, 3, number of beat slots per output word (>=2).
- PAD_BIT, 1'b0, value replicated into unfilled slots on an early flush.
- OUT_W (localparam), IN_W*BEATS, output word width.
- CNT_W (localparam), $clog2(BEATS+1), width of the beat counter and of out_count.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = concatenate, 1 = replicate; sampled only on the first beat of a word.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  IN_W  beat payload.
- in_last  input  1  qualified by in_valid; closes the current word after this beat.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_data  output  OUT_W  assembled word.
- out_count  output  CNT_W  number of real (non-pad) beats in out_data, 1..BEATS.

Behaviour:
- Reset (reset_n=0, takes effect immediately, independent of clk):
  - state=FILL, cnt=0, acc=0.
  - out_valid=0, out_data=0, out_count=0.
  - Any partial word is discarded.
- State FILL:
  - out_valid=0, in_ready=1.
- State HOLD:
  - out_valid=1; out_data and out_count stay stable.
  - in_ready=out_ready, so a new beat may be accepted in the same cycle the word is consumed (full throughput).
  - out_ready=1 with no input beat: go to FILL.
- Slot mapping:
  - Slot k occupies out_data[OUT_W-1-k*IN_W -: IN_W].
  - The first beat of a word (cnt=0) lands in slot 0, the MSB.
- On an accepted beat with cnt=0 and mode=1 (replicate):
  - out_data={BEATS{in_data}}, out_count=BEATS, go to HOLD.
  - in_last has no effect.
- On an accepted beat in concatenate mode (mode=0, or any beat with cnt>0):
  - in_data is written into slot cnt.
  - If cnt==BEATS-1 or in_last=1: register out_data, with slots cnt+1..BEATS-1 set to {IN_W{PAD_BIT}}; set out_count=cnt+1; cnt<=0; go to HOLD.
  - Otherwise: cnt<=cnt+1 and stay in FILL.
- Mode latching:
  - mode is latched at cnt=0.
  - A change of mode while cnt>0 is ignored until the word completes.
- Latency:
  - out_valid rises on the clk edge that accepts the completing beat, i.e. visible the cycle after the handshake.
  - No combinational path from in_data to out_data.
- Flush with no data:
  - Not possible: in_last is ignored when in_valid=0.
- Stale bits:
  - The accumulator must not leak previous-word bits into pad slots.
- Backpressure:
  - While HOLD and out_ready=0: in_ready=0, and out_data/out_count must not change.
  - mode and in_data are don't-care in this condition.
- Simultaneous consume and accept in HOLD:
  - If the accepted beat completes a word (replicate mode, or in_last at cnt=0): stay in HOLD with the new word.
  - Otherwise: go to FILL with cnt=1.

Test Plan:
- Concatenate, IN_W=3, BEATS=3, PAD_BIT=0, mode=0: beats 3'b101, 3'b010, 3'b111 -> out_data=9'b101010111, out_count=3, out_valid high the cycle after the third handshake.
- Replicate, mode=1: single beat 3'b110 -> out_data=9'b110110110, out_count=3. A second beat 3'b001 with out_ready held at 1 is accepted in the same cycle and gives 9'b001001001 on the next cycle.
- Flush:
  - Beat 3'b011 with in_last=1 -> 9'b011000000, out_count=1.
  - Rebuild with PAD_BIT=1: same beat -> 9'b011111111.
  - Beats 3'b100, then 3'b001 with in_last=1 -> 9'b100001111, out_count=2.
- Backpressure: hold out_ready=0 for 5 cycles after a word completes -> in_ready=0 and out_data unchanged throughout. Raise out_ready with in_valid=1 and beat 3'b010 -> word consumed and beat accepted into slot 0 on the same edge.
- Reset mid-word: accept 2 beats, pulse reset_n low between edges -> out_valid=0 and out_count=0 immediately. Beats 3'b111, 3'b000, 3'b111 after release -> 9'b111000111 (no stale data).
- Mode change mid-word: mode=0 on beat 1 (3'b001), mode=1 on beats 2 and 3 (3'b010, 3'b011) -> 9'b001010011, out_count=3.

Source files
------------

// File: rtl/swizzle_packer.sv
// ============================================================================
// Module   : swizzle_packer
// Purpose  : Packs narrow beats into wide words by concatenation or
//            replication, with early flush and pad fill.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module swizzle_packer #(
   parameter  int unsigned IN_W    = 3,
   parameter  int unsigned BEATS   = 3,
   parameter  logic        PAD_BIT = 1'b0,
   localparam int unsigned OUT_W   = IN_W * BEATS,
   localparam int unsigned CNT_W   = $clog2(BEATS + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(BEATS);
   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [OUT_W-1:0]   r_acc;
   logic [OUT_W-1:0]   r_out_data;
   logic [CNT_W-1:0]   r_out_count;

   logic               w_accept;
   logic               w_repl;
   logic               w_close;
   logic [OUT_W-1:0]   w_merged;

   assign in_ready  = (r_state == ST_FILL) | out_ready;
   assign w_accept  = in_valid & in_ready;
   // Mode only matters on the first beat; later beats always concatenate.
   assign w_repl    = (r_cnt == '0) & mode;
   assign w_close   = (r_cnt == C_LAST) | in_last;

   // Slots below cnt keep accumulated data, slot cnt takes the new beat and
   // everything above is padded, so no bits of an earlier word survive.
   generate
      for (genvar k = 0; k < BEATS; k++) begin : g_slot
         localparam logic [CNT_W-1:0] C_K = CNT_W'(k);
         assign w_merged[OUT_W-1-k*IN_W -: IN_W] =
            (C_K < r_cnt)  ? r_acc[OUT_W-1-k*IN_W -: IN_W] :
            (C_K == r_cnt) ? in_data :
                             {IN_W{PAD_BIT}};
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_FILL;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_out_count <= '0;
      end else if (w_accept) begin
         if (w_repl) begin
            r_out_data  <= {BEATS{in_data}};
            r_out_count <= C_FULL;
            r_cnt       <= '0;
            r_state     <= ST_HOLD;
         end else if (w_close) begin
            r_out_data  <= w_merged;
            r_out_count <= r_cnt + C_ONE;
            r_cnt       <= '0;
            r_state     <= ST_HOLD;
         end else begin
            r_acc       <= w_merged;
            r_cnt       <= r_cnt + C_ONE;
            r_state     <= ST_FILL;
         end
      end else if ((r_state == ST_HOLD) && out_ready) begin
         r_state <= ST_FILL;
      end
   end

   assign out_valid = (r_state == ST_HOLD);
   assign out_data  = r_out_data;
   assign out_count = r_out_count;

endmodule

`default_nettype wire

// File: tb/tb_swizzle_packer.sv
// ============================================================================
// Module   : tb_swizzle_packer
// Purpose  : Directed self-checking bench for swizzle_packer (PAD_BIT 0 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_swizzle_packer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       mode;
   logic       in_valid;
   logic [2:0] in_data;
   logic       in_last;
   logic       out_ready;

   logic       in_ready0, out_valid0;
   logic [8:0] out_data0;
   logic [1:0] out_count0;
   logic       in_ready1, out_valid1;
   logic [8:0] out_data1;
   logic [1:0] out_count1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   swizzle_packer #(.IN_W(3), .BEATS(3), .PAD_BIT(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_count(out_count0)
   );

   swizzle_packer #(.IN_W(3), .BEATS(3), .PAD_BIT(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_count(out_count1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [2:0] d, input logic m, input logic l);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      mode     = m;
      in_last  = l;
      n = 0;
      while (!in_ready0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_ready", {31'd0, in_ready0}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("consumed_valid", {31'd0, out_valid0}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
      in_last = 1'b0; out_ready = 1'b0;
      #2;
      chk("rst_valid", {31'd0, out_valid0}, 32'd0);
      chk("rst_data",  {23'd0, out_data0},  32'd0);
      chk("rst_count", {30'd0, out_count0}, 32'd0);
      chk("rst_ready", {31'd0, in_ready0},  32'd1);
      #10 reset_n = 1'b1;
      @(posedge clk); #1;

      // Concatenate three beats
      send(3'b101, 1'b0, 1'b0);
      send(3'b010, 1'b0, 1'b0);
      chk("cat_not_yet", {31'd0, out_valid0}, 32'd0);
      send(3'b111, 1'b0, 1'b0);
      chk("cat_valid", {31'd0, out_valid0}, 32'd1);
      chk("cat_data",  {23'd0, out_data0},  32'h157);
      chk("cat_count", {30'd0, out_count0}, 32'd3);
      chk("cat_data_p1", {23'd0, out_data1}, 32'h157);
      consume();

      // Replicate, then back-to-back replicate with out_ready high
      send(3'b110, 1'b1, 1'b0);
      chk("rep_data",  {23'd0, out_data0},  32'h1B6);
      chk("rep_count", {30'd0, out_count0}, 32'd3);
      out_ready = 1'b1;
      send(3'b001, 1'b1, 1'b0);
      chk("rep2_valid", {31'd0, out_valid0}, 32'd1);
      chk("rep2_data",  {23'd0, out_data0},  32'h049);
      @(posedge clk); #1;
      chk("rep2_drained", {31'd0, out_valid0}, 32'd0);
      out_ready = 1'b0;

      // Replicate ignores in_last
      send(3'b101, 1'b1, 1'b1);
      chk("repl_last_data",  {23'd0, out_data0},  32'h16D);
      chk("repl_last_count", {30'd0, out_count0}, 32'd3);
      consume();

      // Early flush with pad 0 and pad 1
      send(3'b011, 1'b0, 1'b1);
      chk("flush1_data_p0", {23'd0, out_data0},  32'h0C0);
      chk("flush1_data_p1", {23'd0, out_data1},  32'h0FF);
      chk("flush1_count",   {30'd0, out_count0}, 32'd1);
      chk("flush1_valid_p1", {31'd0, out_valid1}, 32'd1);
      consume();
      send(3'b100, 1'b0, 1'b0);
      send(3'b001, 1'b0, 1'b1);
      chk("flush2_data_p0", {23'd0, out_data0},  32'h108);
      chk("flush2_data_p1", {23'd0, out_data1},  32'h10F);
      chk("flush2_count",   {30'd0, out_count0}, 32'd2);
      chk("flush2_count_p1", {30'd0, out_count1}, 32'd2);
      consume();

      // Backpressure for five cycles, then consume and accept together
      send(3'b101, 1'b0, 1'b0);
      send(3'b010, 1'b0, 1'b0);
      send(3'b111, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 3'b010; mode = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_ready",    {31'd0, in_ready0},  32'd0);
         chk("bp_ready_p1", {31'd0, in_ready1},  32'd0);
         chk("bp_valid",    {31'd0, out_valid0}, 32'd1);
         chk("bp_data",     {23'd0, out_data0},  32'h157);
         chk("bp_count",    {30'd0, out_count0}, 32'd3);
      end
      mode = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("bp_release_valid", {31'd0, out_valid0}, 32'd0);
      send(3'b011, 1'b0, 1'b0);
      send(3'b100, 1'b0, 1'b0);
      chk("bp_followon_data", {23'd0, out_data0}, 32'h09C);
      consume();

      // Asynchronous reset mid-word, then no stale bits afterwards
      send(3'b111, 1'b0, 1'b0);
      send(3'b001, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid0}, 32'd0);
      chk("arst_count", {30'd0, out_count0}, 32'd0);
      chk("arst_data",  {23'd0, out_data0},  32'd0);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      send(3'b111, 1'b0, 1'b0);
      send(3'b000, 1'b0, 1'b0);
      send(3'b111, 1'b0, 1'b0);
      chk("post_rst_data",  {23'd0, out_data0},  32'h1C7);
      chk("post_rst_count", {30'd0, out_count0}, 32'd3);
      consume();

      // Mode change mid-word is ignored
      send(3'b001, 1'b0, 1'b0);
      send(3'b010, 1'b1, 1'b0);
      send(3'b011, 1'b1, 1'b0);
      chk("modechg_data",  {23'd0, out_data0},  32'h053);
      chk("modechg_count", {30'd0, out_count0}, 32'd3);
      consume();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
